// File: rtl/muldiv_iter_core.sv
// Iterative radix-2 multiply/divide engine feeding the HI/LO unit.
// Magnitudes are processed for 32 steps, then signs are fixed and HI/LO
// are written on the following edge. Each operation takes a fixed 33 edges.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg;
  logic [WIDTH:0]    acc_reg;     // mul: running high half; div: partial remainder
  logic [WIDTH-1:0]  low_reg;     // mul: multiplier/low product; div: dividend/quotient
  logic [WIDTH-1:0]  opnd_reg;    // mul: multiplicand magnitude; div: divisor magnitude
  logic [WIDTH-1:0]  d1_reg;      // raw dividend, returned as HI on divide by zero
  logic              is_div_reg;
  logic              neg_q_reg;   // negate product / quotient at completion
  logic              neg_r_reg;   // negate remainder at completion
  logic              div_zero_reg;

  logic              running, launch, finish;
  logic [WIDTH-1:0]  mag1, mag2;
  logic [WIDTH:0]    mul_sum, div_shift;
  logic              div_ge;
  logic [WIDTH:0]    acc_step;
  logic [WIDTH-1:0]  low_step;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]  hi_fix, lo_fix;

  assign running = (state_reg == S_RUN);
  assign launch  = (state_reg == S_IDLE) && Start;
  assign finish  = running && (count_reg == '0);
  assign Busy    = Start | running;

  // Operand magnitudes; signed ops use absolute values (0x80..0 maps to itself unsigned).
  assign mag1 = (Op[0] && D1[WIDTH-1]) ? (~D1 + 1'b1) : D1;
  assign mag2 = (Op[0] && D2[WIDTH-1]) ? (~D2 + 1'b1) : D2;

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum   = acc_reg + (low_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {acc_reg[WIDTH-1:0], low_reg[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    acc_step  = '0;
    low_step  = '0;
    if (is_div_reg) begin
      acc_step = div_ge ? (div_shift - {1'b0, opnd_reg}) : div_shift;
      low_step = {low_reg[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {1'b0, mul_sum[WIDTH:1]};
      low_step = {mul_sum[0], low_reg[WIDTH-1:1]};
    end
  end

  // Sign fix-up and special cases applied to the finished magnitudes.
  always_comb begin
    prod_mag = {acc_reg[WIDTH-1:0], low_reg};
    prod_fix = neg_q_reg ? (~prod_mag + 1'b1) : prod_mag;
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      if (div_zero_reg) begin
        hi_fix = d1_reg;
        lo_fix = '1;
      end else begin
        hi_fix = neg_r_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
        lo_fix = neg_q_reg ? (~low_reg + 1'b1) : low_reg;
      end
    end
  end

  // Control state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state: launch from idle, return to idle on the completion edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (Start) state_next = S_RUN;
      S_RUN:   if (count_reg == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: capture operands at launch, iterate while running, publish on finish.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_reg    <= '0;
      acc_reg      <= '0;
      low_reg      <= '0;
      opnd_reg     <= '0;
      d1_reg       <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      Done         <= 1'b0;
      HI           <= '0;
      LO           <= '0;
    end else begin
      Done <= finish;
      if (launch) begin
        count_reg    <= CW'(WIDTH);
        acc_reg      <= '0;
        low_reg      <= Op[1] ? mag1 : mag2;
        opnd_reg     <= Op[1] ? mag2 : mag1;
        d1_reg       <= D1;
        is_div_reg   <= Op[1];
        neg_q_reg    <= Op[0] && (D1[WIDTH-1] ^ D2[WIDTH-1]);
        neg_r_reg    <= Op[0] && D1[WIDTH-1];
        div_zero_reg <= (D2 == '0);
      end else if (finish) begin
        HI <= hi_fix;
        LO <= lo_fix;
      end else if (running) begin
        count_reg <= count_reg - CW'(1);
        acc_reg   <= acc_step;
        low_reg   <= low_step;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_iter_core.sv
// Directed bench for muldiv_iter_core with hand-computed HI/LO results.
module tb_muldiv_iter_core;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] D1 = '0;
  logic [31:0] D2 = '0;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_fails  = 0;

  muldiv_iter_core #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .D1(D1), .D2(D2),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a launch away from the clock edge; returns #1 after the launch edge.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; D1 = a; D2 = b;
    #1 check("busy_on_start", Busy, 1);
    @(posedge Clk); #1;
    Start = 1'b0; Op = 2'b00; D1 = 32'hDEADBEEF; D2 = 32'h12345678;
  endtask

  // Counts edges until Done is seen (bounded), watching HI/LO stay stable meanwhile.
  task automatic wait_done(input int edges_in, output int edges);
    logic [31:0] h0, l0;
    logic        moved;
    h0 = HI; l0 = LO; moved = 1'b0;
    edges = edges_in;
    while (edges < 45) begin
      @(posedge Clk); edges++; #1;
      if (Done) break;
      if (HI !== h0 || LO !== l0) moved = 1'b1;
    end
    check("hilo_hold", moved, 0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int e;
    launch(op, a, b);
    wait_done(0, e);
    check({tag, "_lat"}, e, 33);
    check({tag, "_hi"}, HI, ehi);
    check({tag, "_lo"}, LO, elo);
    @(posedge Clk); #1;
    check({tag, "_done_pulse"}, {Done, Busy}, 2'b00);
    $display("op=%0d d1=%h d2=%h -> HI=%h LO=%h", op, a, b, HI, LO);
  endtask

  initial begin
    int  e;
    logic seen;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_state", {HI, LO, 30'b0, Done, Busy}, 64'h0);
    @(negedge Clk); Rst = 1'b1;
    @(negedge Clk);

    run_op("smul_neg",  2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("umul_max",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("smul_min",  2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("udiv",      2'b10, 32'd100,      32'd7,        32'd2,        32'd14);
    run_op("udiv_zero", 2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
    run_op("sdiv_neg",  2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("sdiv_ovf",  2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("sdiv_zero", 2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);

    // Start during a run is ignored; a Start in the Done cycle launches back-to-back.
    launch(2'b10, 32'd1000, 32'd10);
    repeat (4) @(posedge Clk);
    #1;
    Start = 1'b1; Op = 2'b00; D1 = 32'd3; D2 = 32'd3;
    @(posedge Clk); #1;
    check("busy_ignored_start", Busy, 1);
    Start = 1'b0;
    wait_done(5, e);
    check("ign_lat", e, 33);
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd100);
    $display("ignored-start run -> HI=%h LO=%h", HI, LO);
    launch(2'b11, 32'd7, 32'hFFFFFFFE);
    wait_done(0, e);
    check("b2b_lat", e, 33);
    check("b2b_hi", HI, 32'd1);
    check("b2b_lo", LO, 32'hFFFFFFFD);
    $display("back-to-back run -> HI=%h LO=%h", HI, LO);
    @(posedge Clk); #1;

    // Reset ten edges into an operation discards it.
    launch(2'b01, 32'd5, 32'd5);
    repeat (10) @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    check("midrst_hilo", {HI, LO}, 64'h0);
    check("midrst_busy", Busy, 0);
    @(negedge Clk); Rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done) seen = 1'b1;
    end
    check("midrst_no_done", seen, 0);
    check("midrst_hilo_after", {HI, LO}, 64'h0);
    $display("mid-op reset -> HI=%h LO=%h", HI, LO);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
